// File: rtl/bin_string_serializer.sv
// rtl/bin_string_serializer.sv - frame-wide parallel-to-serial stage with valid/ready on both sides, MSB first
// Optional sync-word preamble ahead of each frame: BIN_SERIALIZER_PREAMBLE_EN
module bin_string_serializer #(
    parameter int NUM_CHARS = 64,
    parameter int CHAR_W    = 8
`ifdef BIN_SERIALIZER_PREAMBLE_EN
    ,
    parameter logic [15:0] PREAMBLE = 16'hA5C3
`endif
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        load_valid,
    output logic                        load_ready,
    input  logic [NUM_CHARS*CHAR_W-1:0] bin_string,
    output logic                        bit_out,
    output logic                        bit_valid,
    input  logic                        bit_ready,
    output logic                        frame_start,
    output logic                        frame_end,
    output logic                        busy
);

    localparam int FRAME_W = NUM_CHARS * CHAR_W;
    localparam int CNT_W   = $clog2(FRAME_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_W - 1);

    typedef enum logic [1:0] {
        S_IDLE,
`ifdef BIN_SERIALIZER_PREAMBLE_EN
        S_PRE,
`endif
        S_DATA
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [FRAME_W-1:0]   shreg;
    logic [CNT_W-1:0]     cnt;
`ifdef BIN_SERIALIZER_PREAMBLE_EN
    logic [15:0]          pre_sh;
    logic [3:0]           pre_cnt;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // All outputs are functions of the registered state only, so they hold during stalls
    always_comb begin
        state_nxt   = state;
        load_ready  = 1'b0;
        bit_valid   = 1'b0;
        bit_out     = 1'b0;
        frame_start = 1'b0;
        frame_end   = 1'b0;
        case (state)
            S_IDLE: begin
                load_ready = 1'b1;
                if (load_valid) begin
`ifdef BIN_SERIALIZER_PREAMBLE_EN
                    state_nxt = S_PRE;
`else
                    state_nxt = S_DATA;
`endif
                end
            end
`ifdef BIN_SERIALIZER_PREAMBLE_EN
            S_PRE: begin
                bit_valid   = 1'b1;
                bit_out     = pre_sh[15];
                frame_start = (pre_cnt == 4'd0);
                if (bit_ready && pre_cnt == 4'd15) begin
                    state_nxt = S_DATA;
                end
            end
`endif
            S_DATA: begin
                bit_valid   = 1'b1;
                bit_out     = shreg[FRAME_W-1];
`ifndef BIN_SERIALIZER_PREAMBLE_EN
                frame_start = (cnt == '0);
`endif
                frame_end   = (cnt == LAST_BIT);
                if (bit_ready && cnt == LAST_BIT) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
        busy = ~load_ready;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg   <= '0;
            cnt     <= '0;
`ifdef BIN_SERIALIZER_PREAMBLE_EN
            pre_sh  <= '0;
            pre_cnt <= '0;
`endif
        end else if (state == S_IDLE && load_valid) begin
            shreg   <= bin_string;
            cnt     <= '0;
`ifdef BIN_SERIALIZER_PREAMBLE_EN
            pre_sh  <= PREAMBLE;
            pre_cnt <= '0;
`endif
        end else if (state == S_DATA && bit_ready) begin
            shreg <= {shreg[FRAME_W-2:0], 1'b0};
            cnt   <= cnt + CNT_W'(1);
`ifdef BIN_SERIALIZER_PREAMBLE_EN
        end else if (state == S_PRE && bit_ready) begin
            pre_sh  <= {pre_sh[14:0], 1'b0};
            pre_cnt <= pre_cnt + 4'd1;
`endif
        end
    end

endmodule

// File: tb/tb_bin_string_serializer.sv
// tb/tb_bin_string_serializer.sv - table vectors plus queue-model scoreboard for bin_string_serializer
module tb_bin_string_serializer;

    localparam int NC = 64;
    localparam int CW = 8;
    localparam int FW = NC * CW;
`ifdef BIN_SERIALIZER_PREAMBLE_EN
    localparam int PRE_N = 16;
`else
    localparam int PRE_N = 0;
`endif
    localparam logic [15:0] PRE_WORD = 16'hA5C3;
    localparam int TOTAL = FW + PRE_N;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          load_valid = 1'b0;
    logic          load_ready;
    logic [FW-1:0] bin_string = '0;
    logic          bit_out;
    logic          bit_valid;
    logic          bit_ready = 1'b0;
    logic          frame_start;
    logic          frame_end;
    logic          busy;

    bin_string_serializer dut (
        .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(load_ready),
        .bin_string(bin_string), .bit_out(bit_out), .bit_valid(bit_valid),
        .bit_ready(bit_ready), .frame_start(frame_start), .frame_end(frame_end),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Reference: queue of bits still owed for the current frame; empty means idle
    bit q[$];
    int pos = 0;
    int cyc = 0;
    int last_acc = -1;
    int nacc = 0;
    bit gap_chk = 1'b0;

    typedef struct {
        logic       r;
        logic       lv;
        logic       br;
        logic [5:0] exp;   // {load_ready, busy, bit_valid, bit_out, frame_start, frame_end}
    } vec_t;
    vec_t tbl[14];

    function automatic vec_t mk(input logic r, input logic lv, input logic br, input logic [5:0] e);
        vec_t v;
        v.r = r; v.lv = lv; v.br = br; v.exp = e;
        return v;
    endfunction

    function automatic logic [FW-1:0] rand_frame();
        logic [FW-1:0] f;
        for (int i = 0; i < FW / 32; i++) f[i*32 +: 32] = $urandom();
        return f;
    endfunction

    task automatic check6(input string name, input logic [5:0] act, input logic [5:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s cyc=%0d actual=%b required=%b", name, cyc, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s cyc=%0d actual=%0d required=%0d", name, cyc, act, exp);
        end
    endtask

    task automatic load_model(input logic [FW-1:0] f);
        for (int i = PRE_N - 1; i >= 0; i--) q.push_back(PRE_WORD[i]);
        for (int i = FW - 1; i >= 0; i--) q.push_back(f[i]);
    endtask

    task automatic tick(input logic r, input logic lv, input logic br, input logic [FW-1:0] f);
        logic [5:0] e;
        bit busy_m;
        rst = r; load_valid = lv; bit_ready = br; bin_string = f;
        #1;
        busy_m = (q.size() != 0);
        if (busy_m) e = {1'b0, 1'b1, 1'b1, q[0], pos == 0, q.size() == 1};
        else        e = 6'b100000;
        check6("outputs", {load_ready, busy, bit_valid, bit_out, frame_start, frame_end}, e);
        if (gap_chk && busy_m && pos == 0 && last_acc >= 0) begin
            check_int("gap", cyc - last_acc, 2);
            last_acc = -1;
        end
        if (bit_valid && bit_ready) nacc++;
        @(posedge clk); #1;
        if (r) begin
            q.delete(); pos = 0;
        end else if (busy_m) begin
            if (br) begin
                if (q.size() == 1) last_acc = cyc;
                void'(q.pop_front());
                pos++;
            end
        end else if (lv) begin
            load_model(f); pos = 0; nacc = 0;
        end
        cyc++;
    endtask

    function automatic logic pick_ready(input int mode, input int k);
        if (mode == 1) return (k % 4 == 0) || (k % 4 == 3);
        if (mode == 2) return $urandom_range(0, 3) != 0;
        return 1'b1;
    endfunction

    task automatic finish_frame(input int mode, input logic [FW-1:0] f);
        int k = 0;
        while (q.size() != 0 && k < 4 * TOTAL + 16) begin
            tick(1'b0, 1'b0, pick_ready(mode, k), f);
            k++;
        end
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL timeout cyc=%0d actual=%0d bits pending required=0", cyc, q.size());
            q.delete();
        end
    endtask

    task automatic run_frame(input int mode, input logic [FW-1:0] f);
        tick(1'b0, 1'b1, 1'b1, f);
        finish_frame(mode, f);
    endtask

    logic [FW-1:0] fa, f1, f55, cur;
    int loaded;

    initial begin
        fa  = {8'h41, {(FW-8){1'b0}}};
        f55 = {NC{8'h55}};

        tbl[0]  = mk(0, 0, 1, 6'b100000);
        tbl[1]  = mk(0, 1, 1, 6'b100000);
`ifdef BIN_SERIALIZER_PREAMBLE_EN
        tbl[2]  = mk(0, 1, 0, 6'b011110);
        tbl[3]  = mk(0, 0, 1, 6'b011110);
        tbl[4]  = mk(0, 0, 1, 6'b011000);
        tbl[5]  = mk(0, 0, 1, 6'b011100);
        tbl[6]  = mk(0, 0, 1, 6'b011000);
        tbl[7]  = mk(0, 0, 1, 6'b011000);
        tbl[8]  = mk(0, 0, 1, 6'b011100);
        tbl[9]  = mk(0, 0, 1, 6'b011000);
        tbl[10] = mk(0, 0, 1, 6'b011100);
        tbl[11] = mk(0, 0, 0, 6'b011100);
        tbl[12] = mk(1, 0, 0, 6'b011100);
`else
        tbl[2]  = mk(0, 1, 0, 6'b011010);
        tbl[3]  = mk(0, 0, 1, 6'b011010);
        tbl[4]  = mk(0, 0, 1, 6'b011100);
        tbl[5]  = mk(0, 0, 1, 6'b011000);
        tbl[6]  = mk(0, 0, 1, 6'b011000);
        tbl[7]  = mk(0, 0, 1, 6'b011000);
        tbl[8]  = mk(0, 0, 1, 6'b011000);
        tbl[9]  = mk(0, 0, 1, 6'b011000);
        tbl[10] = mk(0, 0, 1, 6'b011100);
        tbl[11] = mk(0, 0, 0, 6'b011000);
        tbl[12] = mk(1, 0, 0, 6'b011000);
`endif
        tbl[13] = mk(0, 0, 1, 6'b100000);

        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        bin_string = fa;
        for (int i = 0; i < 14; i++) begin
            rst = tbl[i].r; load_valid = tbl[i].lv; bit_ready = tbl[i].br;
            #1;
            check6("table", {load_ready, busy, bit_valid, bit_out, frame_start, frame_end}, tbl[i].exp);
            @(posedge clk); #1;
            cyc++;
        end

        // "A" frame at full rate; all-ones with 1,0,0,1 back-pressure
        run_frame(0, fa);
        check_int("transfers_a", nacc, TOTAL);
        run_frame(1, {FW{1'b1}});
        check_int("transfers_ones", nacc, TOTAL);

        // Load attempt while busy is ignored; the pending frame loads in the first idle cycle
        f1 = rand_frame();
        tick(1'b0, 1'b1, 1'b1, f1);
        while (q.size() != 0 && cyc < 60000) tick(1'b0, pos >= 100, 1'b1, (pos >= 100) ? f55 : f1);
        run_frame(0, f55);

        // Mid-frame reset, then a clean restart
        f1 = rand_frame();
        tick(1'b0, 1'b1, 1'b1, f1);
        while (pos < 300 && q.size() != 0 && cyc < 60000) tick(1'b0, 1'b0, 1'b1, f1);
        tick(1'b1, 1'b0, 1'b0, f1);
        tick(1'b0, 1'b0, 1'b1, f1);
        run_frame(2, rand_frame());

        run_frame(0, {8'h48, 8'h69, {(FW-16){1'b0}}});

        // Back-to-back with load_valid held high and random back-pressure
        gap_chk = 1'b1;
        last_acc = -1;
        loaded = 0;
        cur = rand_frame();
        while (loaded < 4 && cyc < 90000) begin
            if (q.size() == 0) begin
                tick(1'b0, 1'b1, pick_ready(2, cyc), cur);
                loaded++;
                cur = rand_frame();
            end else begin
                tick(1'b0, 1'b1, pick_ready(2, cyc), cur);
            end
        end
        finish_frame(0, cur);
        gap_chk = 1'b0;
        tick(1'b0, 1'b0, 1'b1, cur);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
        $fatal(1);
    end

endmodule
